line_raster_engine: RTL

// - Full-octant Bresenham line rasteriser. Takes two endpoints and emits one pixel per accepted beat.
// - Generalises the single-octant error/y-step unit: steep-line swap, endpoint reorder, signed ystep.
// - Adds a valid/ready pixel stream with back-pressure and a start/busy/done command handshake.
// - Sits between the primitive setup stage and the framebuffer write port.

---
 rtl/line_raster_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/line_raster_engine.sv
// rtl/line_raster_engine.sv - full-octant Bresenham line rasteriser with valid/ready pixel stream
//
// Captures two signed endpoints on a start strobe and streams every pixel of
// the line, one per accepted beat, in ascending major-axis order.
//
// Build macro: LINE_CLIP_EN - pixels outside [0,XMAX]x[0,YMAX] are suppressed
// while the stepper keeps advancing; XMAX/YMAX exist only in that build.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   start, x0, y0, x1, y1 command strobe and signed endpoints, taken in IDLE
//   busy                  high from the cycle after start is taken through DONE
//   done                  one-cycle pulse after the final pixel beat
//   pix_valid, pix_ready  pixel stream handshake
//   pix_x, pix_y          signed pixel coordinate
//   pix_last              marks the final pixel of the line
module line_raster_engine #(
  parameter int WIDTH = 13
`ifdef LINE_CLIP_EN
  ,
  parameter int XMAX = 639,
  parameter int YMAX = 479
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             busy,
  output logic             done,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] pix_x,
  output logic [WIDTH-1:0] pix_y,
  output logic             pix_last
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP, S_DONE} state_t;
  state_t state, state_nxt;

`ifdef LINE_CLIP_EN
  localparam logic signed [WIDTH-1:0] XMAX_C = WIDTH'(XMAX);
  localparam logic signed [WIDTH-1:0] YMAX_C = WIDTH'(YMAX);
`endif

  // captured endpoints
  logic signed [WIDTH-1:0] rx0, ry0, rx1, ry1;
  // stepper state, in the (possibly swapped) major/minor frame
  logic signed [WIDTH-1:0] cur_x, cur_y, end_x;
  logic signed [WIDTH:0]   dx_r, dy_r;
  logic signed [WIDTH+1:0] err_r;
  logic                    steep_r, yneg_r;

  // setup datapath
  logic signed [WIDTH:0]   ddx, ddy, adx, ady, s_dx, s_dy_raw, s_dy;
  logic signed [WIDTH-1:0] pa_x, pa_y, pb_x, pb_y, sa_x, sa_y, sb_x, sb_y;
  logic                    steep;

  // step datapath
  logic signed [WIDTH+1:0] err_dec;
  logic signed [WIDTH-1:0] px, py;
  logic                    at_end, in_step, visible, advance;

  // Deltas are taken one bit wider than the coordinates so full-range
  // endpoints cannot overflow.
  always_comb begin
    ddx   = {rx1[WIDTH-1], rx1} - {rx0[WIDTH-1], rx0};
    ddy   = {ry1[WIDTH-1], ry1} - {ry0[WIDTH-1], ry0};
    adx   = ddx[WIDTH] ? -ddx : ddx;
    ady   = ddy[WIDTH] ? -ddy : ddy;
    steep = ady > adx;
    pa_x  = steep ? ry0 : rx0;
    pa_y  = steep ? rx0 : ry0;
    pb_x  = steep ? ry1 : rx1;
    pb_y  = steep ? rx1 : ry1;
    if (pa_x > pb_x) begin
      sa_x = pb_x;
      sa_y = pb_y;
      sb_x = pa_x;
      sb_y = pa_y;
    end else begin
      sa_x = pa_x;
      sa_y = pa_y;
      sb_x = pb_x;
      sb_y = pb_y;
    end
    s_dx     = {sb_x[WIDTH-1], sb_x} - {sa_x[WIDTH-1], sa_x};
    s_dy_raw = {sb_y[WIDTH-1], sb_y} - {sa_y[WIDTH-1], sa_y};
    s_dy     = s_dy_raw[WIDTH] ? -s_dy_raw : s_dy_raw;
  end

  always_comb begin
    err_dec = err_r - {dy_r[WIDTH], dy_r};
    at_end  = (cur_x == end_x);
    in_step = (state == S_STEP);
    px      = steep_r ? cur_y : cur_x;
    py      = steep_r ? cur_x : cur_y;
`ifdef LINE_CLIP_EN
    visible = !px[WIDTH-1] && (px <= XMAX_C) && !py[WIDTH-1] && (py <= YMAX_C);
`else
    visible = 1'b1;
`endif
    // An invisible pixel never waits for the consumer.
    advance   = in_step && (pix_ready || !visible);
    pix_valid = in_step && visible;
    pix_last  = in_step && visible && at_end;
    pix_x     = px;
    pix_y     = py;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_STEP;
      S_STEP:  if (advance && at_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rx0     <= '0;
      ry0     <= '0;
      rx1     <= '0;
      ry1     <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      end_x   <= '0;
      dx_r    <= '0;
      dy_r    <= '0;
      err_r   <= '0;
      steep_r <= 1'b0;
      yneg_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          rx0 <= x0;
          ry0 <= y0;
          rx1 <= x1;
          ry1 <= y1;
        end
        S_SETUP: begin
          steep_r <= steep;
          cur_x   <= sa_x;
          cur_y   <= sa_y;
          end_x   <= sb_x;
          dx_r    <= s_dx;
          dy_r    <= s_dy;
          err_r   <= {2'b00, s_dx[WIDTH:1]};  // dx is non-negative, so >>>1 == >>1
          yneg_r  <= !(sa_y < sb_y);
        end
        S_STEP: if (advance && !at_end) begin
          cur_x <= cur_x + WIDTH'(1);
          // dy <= dx, so a single +dx always restores a non-negative error.
          if (err_dec[WIDTH+1]) begin
            cur_y <= yneg_r ? cur_y - WIDTH'(1) : cur_y + WIDTH'(1);
            err_r <= err_dec + {dx_r[WIDTH], dx_r};
          end else begin
            err_r <= err_dec;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
